// File: rtl/market_pkg.sv
// Shared constants for the order feeder and the price matching engine.
package market_pkg;

    localparam int PRICE_W = 8;

    // Idle "no order" values the engine expects on its price inputs.
    localparam logic [PRICE_W-1:0] BUY_IDLE  = {PRICE_W{1'b0}};
    localparam logic [PRICE_W-1:0] SELL_IDLE = {PRICE_W{1'b1}};

    // Side encoding of the host order interface.
    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

endpackage

// File: rtl/order_fifo.sv
// Synchronous FIFO holding the pending orders for one side.
// Pop on empty and push on full are ignored so the pointers can never
// run past each other.
module order_fifo #(
    parameter int PRICE_W = market_pkg::PRICE_W,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [PRICE_W-1:0]       push_data,
    input  logic                     pop,
    output logic [PRICE_W-1:0]       head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PRICE_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [CW-1:0]      count_r;
    logic               do_push_s;
    logic               do_pop_s;

    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});
    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

    // Qualify the requests so overflow and underflow cannot corrupt state.
    always_comb begin
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
    end

    // Storage array: written at the tail on an accepted push.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {PRICE_W{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/order_feeder.sv
// Feeds one buy and one sell price per clock into the matching engine,
// buffering host orders per side and substituting idle values when a
// side has nothing to issue.
module order_feeder #(
    parameter int                  PRICE_W   = market_pkg::PRICE_W,
    parameter int                  DEPTH     = 4,
    parameter logic [PRICE_W-1:0]  BUY_IDLE  = {PRICE_W{1'b0}},
    parameter logic [PRICE_W-1:0]  SELL_IDLE = {PRICE_W{1'b1}}
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_side,
    input  logic [PRICE_W-1:0]       in_price,
    input  logic                     issue_en,
    output logic [PRICE_W-1:0]       buy_price,
    output logic [PRICE_W-1:0]       sell_price,
    output logic [$clog2(DEPTH):0]   buy_count,
    output logic [$clog2(DEPTH):0]   sell_count,
    output logic [7:0]               drop_count
);

    import market_pkg::*;

    logic                 buy_full_s;
    logic                 sell_full_s;
    logic                 buy_empty_s;
    logic                 sell_empty_s;
    logic [PRICE_W-1:0]   buy_head_s;
    logic [PRICE_W-1:0]   sell_head_s;
    logic                 accept_s;
    logic                 idle_order_s;
    logic                 buy_push_s;
    logic                 sell_push_s;
    logic                 buy_pop_s;
    logic                 sell_pop_s;
    logic                 drop_s;
    logic [PRICE_W-1:0]   buy_next_s;
    logic [PRICE_W-1:0]   sell_next_s;
    logic [PRICE_W-1:0]   buy_price_r;
    logic [PRICE_W-1:0]   sell_price_r;
    logic [7:0]           drop_count_r;

    // Ready reflects only the selected side's fullness, never a same-cycle pop.
    always_comb begin
        in_ready = 1'b0;
        if (in_side == SIDE_SELL) begin
            in_ready = !sell_full_s;
        end else begin
            in_ready = !buy_full_s;
        end
    end

    // Route an accepted order to its FIFO, or drop it if it carries the idle value.
    always_comb begin
        accept_s     = in_valid && in_ready;
        idle_order_s = 1'b0;
        if (in_side == SIDE_SELL) begin
            idle_order_s = (in_price == SELL_IDLE);
        end else begin
            idle_order_s = (in_price == BUY_IDLE);
        end
        drop_s      = accept_s && idle_order_s;
        buy_push_s  = accept_s && !idle_order_s && (in_side == SIDE_BUY);
        sell_push_s = accept_s && !idle_order_s && (in_side == SIDE_SELL);
    end

    // Issue selection: head entry when available, idle otherwise or when paused.
    always_comb begin
        buy_pop_s   = 1'b0;
        sell_pop_s  = 1'b0;
        buy_next_s  = BUY_IDLE;
        sell_next_s = SELL_IDLE;
        if (issue_en) begin
            buy_pop_s  = !buy_empty_s;
            sell_pop_s = !sell_empty_s;
            if (!buy_empty_s) begin
                buy_next_s = buy_head_s;
            end else begin
                buy_next_s = BUY_IDLE;
            end
            if (!sell_empty_s) begin
                sell_next_s = sell_head_s;
            end else begin
                sell_next_s = SELL_IDLE;
            end
        end else begin
            buy_next_s  = BUY_IDLE;
            sell_next_s = SELL_IDLE;
        end
    end

    // Price output registers, reloaded every cycle so no price is ever held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buy_price_r  <= BUY_IDLE;
            sell_price_r <= SELL_IDLE;
        end else begin
            buy_price_r  <= buy_next_s;
            sell_price_r <= sell_next_s;
        end
    end

    // Saturating count of idle-valued orders swallowed at the input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_r <= 8'h00;
        end else if (drop_s && (drop_count_r != 8'hFF)) begin
            drop_count_r <= drop_count_r + 8'h01;
        end else begin
            drop_count_r <= drop_count_r;
        end
    end

    assign buy_price  = buy_price_r;
    assign sell_price = sell_price_r;
    assign drop_count = drop_count_r;

    order_fifo #(
        .PRICE_W (PRICE_W),
        .DEPTH   (DEPTH)
    ) u_buy_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (buy_push_s),
        .push_data (in_price),
        .pop       (buy_pop_s),
        .head      (buy_head_s),
        .count     (buy_count),
        .full      (buy_full_s),
        .empty     (buy_empty_s)
    );

    order_fifo #(
        .PRICE_W (PRICE_W),
        .DEPTH   (DEPTH)
    ) u_sell_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (sell_push_s),
        .push_data (in_price),
        .pop       (sell_pop_s),
        .head      (sell_head_s),
        .count     (sell_count),
        .full      (sell_full_s),
        .empty     (sell_empty_s)
    );

endmodule

// File: tb/tb_order_feeder.sv
// Bench for order_feeder: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based model.
module tb_order_feeder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_side;
    logic [7:0] in_price;
    logic       issue_en;
    logic [7:0] buy_price;
    logic [7:0] sell_price;
    logic [2:0] buy_count;
    logic [2:0] sell_count;
    logic [7:0] drop_count;

    int errors = 0;
    int checks = 0;
    bit cmp_on = 1'b0;

    // Reference model state
    logic [7:0] bq[$];
    logic [7:0] sq[$];
    logic [7:0] exp_buy  = 8'h00;
    logic [7:0] exp_sell = 8'hFF;
    int         exp_drop = 0;

    order_feeder #(
        .PRICE_W   (8),
        .DEPTH     (DEPTH),
        .BUY_IDLE  (8'h00),
        .SELL_IDLE (8'hFF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_side    (in_side),
        .in_price   (in_price),
        .issue_en   (issue_en),
        .buy_price  (buy_price),
        .sell_price (sell_price),
        .buy_count  (buy_count),
        .sell_count (sell_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: per-side queues, outputs and drop counter.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bq.delete();
            sq.delete();
            exp_buy  = 8'h00;
            exp_sell = 8'hFF;
            exp_drop = 0;
        end else begin
            bit rdy;
            bit idle;
            rdy  = in_side ? (sq.size() < DEPTH) : (bq.size() < DEPTH);
            idle = in_side ? (in_price == 8'hFF) : (in_price == 8'h00);
            if (issue_en && bq.size() > 0) exp_buy = bq.pop_front();
            else exp_buy = 8'h00;
            if (issue_en && sq.size() > 0) exp_sell = sq.pop_front();
            else exp_sell = 8'hFF;
            if (in_valid && rdy) begin
                if (idle) begin
                    if (exp_drop < 255) exp_drop++;
                end else if (in_side) begin
                    sq.push_back(in_price);
                end else begin
                    bq.push_back(in_price);
                end
            end
        end
    end

    // Compare process: every falling edge once the bench has reset the DUT.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("m_buy_price",  buy_price,  exp_buy);
            check("m_sell_price", sell_price, exp_sell);
            check("m_buy_count",  buy_count,  bq.size());
            check("m_sell_count", sell_count, sq.size());
            check("m_drop_count", drop_count, exp_drop);
            check("m_in_ready",   in_ready,
                  in_side ? (sq.size() < DEPTH) : (bq.size() < DEPTH));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] p, input logic ie);
        in_valid = v;
        in_side  = s;
        in_price = p;
        issue_en = ie;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (2) step();
        #2 reset_n = 1'b1;
        cmp_on = 1'b1;

        // Idle issue with no orders
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_buy", buy_price, 8'h00);
            check("idle_sell", sell_price, 8'hFF);
            check("idle_counts", {buy_count, sell_count}, 6'd0);
        end

        // Single buy latency
        drive(1'b1, 1'b0, 8'h40, 1'b1);
        step();
        check("lat_count_after_push", buy_count, 3'd1);
        check("lat_no_bypass", buy_price, 8'h00);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        step();
        check("lat_issue", buy_price, 8'h40);
        check("lat_sell_idle", sell_price, 8'hFF);
        step();
        check("lat_one_cycle", buy_price, 8'h00);

        // Fill buy FIFO while paused
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 8'(i * 16), 1'b0);
            step();
        end
        check("fill_count", buy_count, 3'd4);
        drive(1'b1, 1'b0, 8'h50, 1'b0);
        #1 check("full_ready_buy", in_ready, 1'b0);
        in_side = 1'b1;
        #1 check("full_ready_sell", in_ready, 1'b1);
        in_side = 1'b0;
        step();
        check("stall_count", buy_count, 3'd4);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("drain_order", buy_price, 8'(i * 16));
        end
        step();
        check("drain_idle", buy_price, 8'h00);

        // Idle-valued orders are dropped
        drive(1'b1, 1'b0, 8'h00, 1'b1);
        step();
        drive(1'b1, 1'b1, 8'hFF, 1'b1);
        step();
        check("drop_two", drop_count, 8'd2);
        check("drop_counts", {buy_count, sell_count}, 6'd0);
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, i[0], i[0] ? 8'hFF : 8'h00, 1'b1);
            step();
        end
        check("drop_saturate", drop_count, 8'd255);

        // Alternating buy/sell stream
        drive(1'b1, 1'b0, 8'h50, 1'b1);
        step();
        drive(1'b1, 1'b1, 8'h4C, 1'b1);
        step();
        check("stream_buy", buy_price, 8'h50);
        check("stream_sell_count", sell_count, 3'd1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        step();
        check("stream_sell", sell_price, 8'h4C);
        check("stream_buy_idle", buy_price, 8'h00);

        // Reset mid-stream with sells pending
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 8'(8'h80 + i), 1'b0);
            step();
        end
        check("pre_reset_sell_count", sell_count, 3'd3);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rst_sell_count", sell_count, 3'd0);
        check("rst_sell_price", sell_price, 8'hFF);
        check("rst_drop", drop_count, 8'd0);
        step();
        #2 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_sell", sell_price, 8'hFF);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] p;
            p = 8'($urandom);
            if ($urandom_range(0, 9) == 0) p = 8'h00;
            if ($urandom_range(0, 9) == 0) p = 8'hFF;
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), p,
                  1'($urandom_range(0, 9) < 6));
            if ($urandom_range(0, 599) == 0) begin
                reset_n = 1'b0;
                step();
                #2 reset_n = 1'b1;
            end else begin
                step();
            end
        end

        drive(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
